prog_mem_loader: RTL

Serial program-image loader: the write-side counterpart of the program memory read port. It consumes a byte stream from a host link (UART receiver or bench driver) and parses a framed image: sync, word count, data, checksum. It writes 16-bit words into program memory and holds the CPU off while the image is in flight. It sits between the host receive path and the program memory write port, alongside `avr_fetch`.

---
 rtl/avr_loader_pkg.sv | 21 ++
 rtl/prog_mem_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/avr_loader_pkg.sv
// Shared types and constants for the serial program-image loader.
// Imported by prog_mem_loader.
package avr_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_BYTE_HI,
    S_BYTE_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] SYNC_DEF = 8'h55;
  localparam int CHK_W = 8;
  localparam int CNT_W = 16;

endpackage

// File: rtl/prog_mem_loader.sv
// Parses a framed byte stream (sync, count, data, checksum) into
// 16-bit program memory writes and holds the CPU while loading.
module prog_mem_loader
  import avr_loader_pkg::*;
#(
  parameter int         ADDR_W    = 9,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [CNT_W:0] MAX_N =
    (CNT_W+1)'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CHK_W-1:0]    sum_q, sum_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rdy_q, rdy_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                fire;
  logic [CNT_W-1:0]    n_w;
  logic [CHK_W-1:0]    sum_nx;

  assign fire   = rx_valid && rdy_q;
  assign n_w    = {cnt_q[15:8], rx_data};
  assign sum_nx = sum_q + rx_data;

  // Next-state, datapath and status decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (fire && rx_data == SYNC_BYTE) begin
          state_d = S_CNT_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      S_CNT_HI: begin
        if (fire) begin
          cnt_d   = {rx_data, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (fire) begin
          cnt_d = n_w;
          if (n_w == '0) begin
            state_d = S_CHK;
          end else if ({1'b0, n_w} > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_BYTE_HI;
          end
        end
      end
      S_BYTE_HI: begin
        if (fire) begin
          hi_d    = rx_data;
          sum_d   = sum_nx;
          state_d = S_BYTE_LO;
        end
      end
      S_BYTE_LO: begin
        if (fire) begin
          wdata_d = {hi_q, rx_data};
          sum_d   = sum_nx;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_CHK
                                       : S_BYTE_HI;
      end
      S_CHK: begin
        if (fire) begin
          if (sum_nx == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    we_d  = (state_d == S_WRITE);
    rdy_d = (state_d != S_WRITE);
  end

  // State and registered outputs; reset wins over any byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b1;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready  = rdy_q;
  assign pm_we     = we_q;
  assign pm_addr   = addr_q;
  assign pm_wdata  = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
